i2s_sample_feeder: RTL
======================

# i2s_sample_feeder

Buffers audio samples from a producer (DDS, memory player, test generator) and serves them one per request to the `i2s` transmitter. It sits directly upstream of `i2s`:
- drives its `sample` and `in_en` inputs;
- consumes its `out_ready` request pulse;
- detects underruns.

## Interface

Parameters:
- `BPS`, 24: sample width in bits; must match `i2s` `BPS`.
- `DEPTH`, 16: FIFO depth in samples; power of two, ≥4.
- `PREFILL`, 8: FIFO level required before playback starts; 1..DEPTH.

Ports:
- `in_clk`, input, 1: system clock, 73.728 MHz; same clock as `i2s`.
- `in_rst_n`, input, 1: reset, asynchronous, active-low.
- `in_run`, input, 1: playback request level.
- `in_valid`, input, 1: producer write strobe.
- `in_data`, input, BPS: producer sample.
- `out_wr_ready`, output, 1: FIFO not full; a write is accepted when `in_valid & out_wr_ready`.
- `in_i2s_ready`, input, 1: connected to `i2s` `out_ready`.
- `out_sample`, output, BPS: connected to `i2s` `sample`.
- `out_en`, output, 1: connected to `i2s` `in_en`.
- `out_level`, output, clog2(DEPTH)+1: current FIFO occupancy.
- `out_underrun`, output, 1: sticky flag; cleared only by reset.
- `out_underrun_cnt`, output, 16: saturating underrun counter.

## Operation

- **Request detection.** Register `in_i2s_ready` into `rdy_q` (reset value 1). `req = in_i2s_ready & ~rdy_q`, a rising edge. The constant-high level of `i2s` in IDLE never produces `req`.
- **IDLE:**
  - `out_en` = 0.
  - When `in_run` = 1 and `out_level` ≥ PREFILL: pop the FIFO head into `out_sample`, then go to PRIME.
- **PRIME:** set `out_en` = 1, then go to RUN. `i2s` captures `out_sample` on the cycle it first sees `out_en` high.
- **RUN:**
  - On `req` with the FIFO non-empty: pop the head into `out_sample`.
  - On `req` with the FIFO empty: `out_sample` ← 0, set `out_underrun`, increment `out_underrun_cnt` (saturates at 0xFFFF).
  - If `in_run` = 0: `out_en` ← 0, go to STOP. A `req` in that same cycle is still serviced (pop or underrun).
- **STOP:**
  - `out_en` = 0 and no pops occur.
  - Wait for `req`. `i2s` sees `in_en` low at its next request, returns to IDLE and raises `out_ready`.
  - On `req`, go to IDLE.
- The FIFO contents persist across STOP/IDLE. Playback restarts only after PREFILL is met again.
- **FIFO:**
  - Push when `in_valid & out_wr_ready`.
  - `out_wr_ready` is evaluated from the pre-pop level, so a push at full is refused even if a pop occurs in the same cycle.
  - Simultaneous push and pop at level L (0 < L < DEPTH): level is unchanged, and the popped value is the old head.
  - Pop at level 0: counts as an underrun even if a push occurs in the same cycle. The pushed value is stored.
  - Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Level is one bit wider, so full (== DEPTH) and empty are distinct.

## Timing

- **Reset values:** `out_sample` = 0, `out_en` = 0, `out_wr_ready` = 1, `out_level` = 0, `out_underrun` = 0, `out_underrun_cnt` = 0, state = IDLE, `rdy_q` = 1.
- **Reset mid-operation:** all state clears immediately (asynchronous); FIFO contents are discarded.
- **Startup latency:**
  - Cycle 0: the PREFILL condition is met.
  - Cycle 1: `out_sample` is loaded.
  - Cycle 2: `out_en` = 1.
- **Request latency:** `out_sample` updates on the clock edge after `rdy_q` sees the rise, i.e. 2 cycles after `in_i2s_ready` goes high. `i2s` loads 5 cycles after its ready pulse, leaving 3 cycles of margin.
- **Stability:** `out_sample` is stable from 2 cycles after one `req` until the next `req`.
- **Stop latency:** `out_en` falls 1 cycle after `in_run` falls in RUN.
- `out_level` and `out_wr_ready` are registered and update 1 cycle after a push or pop.

## Structure

- Package `audio_pkg` holds:
  - the state encoding constants `FEED_IDLE`=2'd0, `FEED_PRIME`=2'd1, `FEED_RUN`=2'd2, `FEED_STOP`=2'd3;
  - the shared `BPS` default of 24, also used by `i2s`.
- Sub-module `sample_fifo` (parameters BPS, DEPTH):
  - synchronous single-clock FIFO with push, pop, head data, level, and full/empty;
  - asynchronous active-low reset on pointers and level only; the storage array is not reset.
- The top level contains the FSM, the request edge detector and the underrun logic.

## Test plan

- **Reset mid-operation:** reset after writing 5 samples → all outputs at their reset values; `out_level` = 0.
- **Prefill and start:** `in_run` = 1; write 0x000001..0x000008 (PREFILL = 8) → `out_sample` = 0x000001 one cycle after the 8th write lands; `out_en` = 1 one cycle later; `out_level` = 7.
- **Request service:** with the real `i2s` attached, run 4 requests → samples 0x000001..0x000004 appear MSB-first on PBDAT in left slots. `out_sample` changes exactly 2 cycles after each `out_ready` rise.
- **Underrun:** FIFO emptied in RUN, one further request → `out_sample` = 0, `out_underrun` = 1, `out_underrun_cnt` = 1. A subsequent write is played at the next request.
- **Full and simultaneous events:**
  - Fill to DEPTH = 16 → `out_wr_ready` = 0.
  - A write in the same cycle as a pop at full is refused → `out_level` = 15.
  - A push and pop at level 0 → underrun counted, `out_level` = 1.
- **Stop and restart:** drop `in_run` in RUN → `out_en` = 0 after 1 cycle, no further pops, state returns to IDLE on the next `out_ready` rise. Raise `in_run` again with level ≥ 8 → playback restarts with the FIFO head.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio definitions: default sample width and sample-feeder state encoding.
package audio_pkg;

    localparam int unsigned AUDIO_BPS = 24;

    localparam logic [1:0] FEED_IDLE  = 2'd0;
    localparam logic [1:0] FEED_PRIME = 2'd1;
    localparam logic [1:0] FEED_RUN   = 2'd2;
    localparam logic [1:0] FEED_STOP  = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = FEED_IDLE,
        StPrime = FEED_PRIME,
        StRun   = FEED_RUN,
        StStop  = FEED_STOP
    } feed_state_e;

endpackage

// File: rtl/i2s_sample_feeder_if.sv
// Producer write port and i2s sample port of the sample feeder.
interface i2s_sample_feeder_if #(
    parameter int unsigned BPS = audio_pkg::AUDIO_BPS
);
    logic           in_valid;
    logic [BPS-1:0] in_data;
    logic           out_wr_ready;
    logic           in_i2s_ready;
    logic [BPS-1:0] out_sample;
    logic           out_en;

    modport master (
        output in_valid, in_data, in_i2s_ready,
        input  out_wr_ready, out_sample, out_en
    );

    modport slave (
        input  in_valid, in_data, in_i2s_ready,
        output out_wr_ready, out_sample, out_en
    );
endinterface

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO; pointers and level are reset, storage is not.
module sample_fifo #(
    parameter int unsigned BPS   = 24,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [BPS-1:0]         wdata_i,
    input  logic                   pop_i,
    output logic [BPS-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    logic [BPS-1:0]  mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic            push_ok, pop_ok;

    assign full_o  = (level_q == LvlW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Acceptance uses the pre-pop level: a push at full is refused even alongside a pop.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
        rd_ptr_d = rd_ptr_q + PtrW'(pop_ok);
        level_d  = level_q + LvlW'(push_ok) - LvlW'(pop_ok);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end
endmodule

// File: rtl/i2s_sample_feeder.sv
// Buffers producer samples and hands one to the i2s transmitter per request, flagging underruns.
module i2s_sample_feeder
    import audio_pkg::*;
#(
    parameter int unsigned BPS     = AUDIO_BPS,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned PREFILL = 8
) (
    input  logic                   in_clk,
    input  logic                   in_rst_n,
    input  logic                   in_run,
    i2s_sample_feeder_if.slave     bus,
    output logic [$clog2(DEPTH):0] out_level,
    output logic                   out_underrun,
    output logic [15:0]            out_underrun_cnt
);
    localparam int unsigned LvlW = $clog2(DEPTH) + 1;

    feed_state_e    state_q, state_d;
    logic           rdy_q, rdy_d, req_q, req_d;
    logic [BPS-1:0] sample_q, sample_d;
    logic           en_q, en_d;
    logic           underrun_q, underrun_d;
    logic [15:0]    ucnt_q, ucnt_d;
    logic           pop;
    logic [BPS-1:0] fifo_head;
    logic           fifo_full, fifo_empty;

    sample_fifo #(
        .BPS   (BPS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (in_clk),
        .rst_ni  (in_rst_n),
        .push_i  (bus.in_valid),
        .wdata_i (bus.in_data),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .level_o (out_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.out_wr_ready = ~fifo_full;
    assign bus.out_sample   = sample_q;
    assign bus.out_en       = en_q;
    assign out_underrun     = underrun_q;
    assign out_underrun_cnt = ucnt_q;

    always_comb begin
        rdy_d      = bus.in_i2s_ready;
        // Rising edge of i2s ready, registered so the sample lands 2 cycles after the rise.
        req_d      = bus.in_i2s_ready & ~rdy_q;
        state_d    = state_q;
        sample_d   = sample_q;
        en_d       = en_q;
        underrun_d = underrun_q;
        ucnt_d     = ucnt_q;
        pop        = 1'b0;

        unique case (state_q)
            StIdle: begin
                en_d = 1'b0;
                if (in_run && (out_level >= LvlW'(PREFILL))) begin
                    pop      = 1'b1;
                    sample_d = fifo_head;
                    state_d  = StPrime;
                end
            end
            StPrime: begin
                en_d    = 1'b1;
                state_d = StRun;
            end
            StRun: begin
                if (req_q) begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        sample_d = fifo_head;
                    end else begin
                        sample_d   = '0;
                        underrun_d = 1'b1;
                        if (ucnt_q != 16'hFFFF) begin
                            ucnt_d = ucnt_q + 16'd1;
                        end
                    end
                end
                if (!in_run) begin
                    en_d    = 1'b0;
                    state_d = StStop;
                end
            end
            StStop: begin
                en_d = 1'b0;
                if (req_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q    <= StIdle;
            rdy_q      <= 1'b1;
            req_q      <= 1'b0;
            sample_q   <= '0;
            en_q       <= 1'b0;
            underrun_q <= 1'b0;
            ucnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            rdy_q      <= rdy_d;
            req_q      <= req_d;
            sample_q   <= sample_d;
            en_q       <= en_d;
            underrun_q <= underrun_d;
            ucnt_q     <= ucnt_d;
        end
    end
endmodule
